hilo_unit: RTL and testbench
============================

# hilo_unit

Parametrised HI/LO register unit with an integrated iterative multiply/divide engine, used by the execute stage of the CPU pipeline. It holds the architectural HI and LO registers and writes each independently for MTHI and MTLO. It runs signed and unsigned MULT and DIV as multi-cycle operations, raising `busy` so the pipeline stalls until the result lands in HI/LO. It also supports cancelling an in-flight operation on a pipeline flush.

## Interface
- `DW`, default 32: data width of operands, HI and LO. Must be at least 4.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `op_valid`  in  1: request strobe. Sampled only when `busy`=0.
- `op`  in  3: operation code.
  - 000 = MULT, 001 = MULTU, 010 = DIV, 011 = DIVU, 100 = MTHI, 101 = MTLO.
  - 110 and 111 are no-ops.
- `src_a`  in  DW: multiplicand or dividend; also the MTHI/MTLO data.
- `src_b`  in  DW: multiplier or divisor.
- `cancel`  in  1: abort any in-flight MULT/DIV (pipeline flush).
- `busy`  out  1: high while a MULT/DIV is in flight.
- `done`  out  1: one-cycle pulse in the cycle the new MULT/DIV result is visible on HI/LO.
- `hi_o`  out  DW: architectural HI register.
- `lo_o`  out  DW: architectural LO register.

## Operation
- **Reset.** Clears `hi_o` and `lo_o` to 0, forces `busy`=0 and `done`=0, and puts the FSM in IDLE.
- **Reset mid-operation.** Same as above; the in-flight result is discarded.
- **FSM states:** IDLE, CALC, FIX.
- **IDLE:**
  - `op_valid`=1 with MTHI writes `hi_o` ← `src_a` at the next edge; LO is unchanged.
  - `op_valid`=1 with MTLO writes `lo_o` ← `src_a` at the next edge; HI is unchanged.
  - Both take one cycle, do not assert `busy` and do not pulse `done`.
  - `op_valid`=1 with MULT/MULTU/DIV/DIVU accepts the operation:
    - Latch the operand magnitudes (absolute values for signed ops; raw values for unsigned ops).
    - Latch the result signs and load a DW-bit iteration counter with DW.
    - Go to CALC; `busy` goes high.
  - DIV/DIVU with `src_b`=0 goes directly to FIX and skips CALC.
- **CALC.** One radix-2 step per cycle, for exactly DW cycles, then go to FIX.
  - Multiply: shift-add into a 2·DW accumulator.
  - Divide: restoring shift-subtract that produces a DW-bit quotient and a DW-bit remainder.
- **FIX.** Apply the sign correction and write HI/LO, then return to IDLE. `busy` drops and `done` pulses.
  - Multiply: the 2·DW product is negated if sign(a) XOR sign(b), signed op only. HI ← upper DW bits, LO ← lower DW bits.
  - Divide: LO ← quotient, negated if sign(a) XOR sign(b). HI ← remainder, negated if sign(a). The remainder sign follows the dividend.
- **Divide by zero.** HI ← `src_a` as given, LO ← all ones, for both DIV and DIVU.
- **Signed overflow.** DIV of −2^(DW−1) by −1 gives LO = 2^(DW−1) bit pattern (0x80000000 for DW=32) and HI = 0. No trap.
- **Requests while `busy`=1.** `op_valid` is ignored, MTHI/MTLO included. The pipeline must hold the request until `busy`=0.
- **`cancel`=1:**
  - In CALC or FIX: go to IDLE at the next edge. HI/LO are not written, no `done`, and `busy` is low after that edge.
  - In IDLE: any simultaneous `op_valid` is dropped, MTHI/MTLO included (cancel wins).
- **Simultaneous `rst` and `cancel`.** `rst` wins.

## Timing
- Define E0 as the edge that accepts a MULT/DIV.
- `busy` is high from E0 to E(DW+1). It is registered and has no combinational path from `op_valid`.
- HI/LO are written at E(DW+1). `done` is high for exactly the cycle between E(DW+1) and E(DW+2).
- Total latency is DW+1 edges; for DW=32 that is 33.
- Divide-by-zero: HI/LO are written at E1, `busy` is high between E0 and E1, and `done` is high between E1 and E2.
- Back-to-back operations:
  - A new request may be accepted in the same cycle `done` is high, because `busy`=0.
  - That request's E0 is E(DW+2) of the previous op.
- All outputs are registered.

## Test plan
- **Reset and move-to.** Reset, then MTHI 0x12345678, then MTLO 0x9ABCDEF0.
  - After reset: `hi_o`=`lo_o`=0.
  - One edge after the MTHI: `hi_o`=0x12345678 and `lo_o`=0.
  - After the MTLO: `lo_o`=0x9ABCDEF0 and `hi_o` unchanged.
  - `busy` stays 0 throughout.
- **Multiply, DW=32.** Run MULT 0xFFFFFFFF × 0x00000002, then MULTU with the same operands.
  - MULT: HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU: HI=0x00000001, LO=0xFFFFFFFE.
  - For each op, `done` pulses exactly 33 edges after E0 and `busy` is high for those 33 cycles.
- **Divide.** Run DIV −7 ÷ 2, then DIVU 7 ÷ 0, then DIV 0x80000000 ÷ 0xFFFFFFFF.
  - DIV −7 ÷ 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7 ÷ 0: HI=7, LO=0xFFFFFFFF, `done` one edge after E0.
  - DIV 0x80000000 ÷ 0xFFFFFFFF: LO=0x80000000, HI=0.
- **Cancel.**
  - Pre-set HI=0xAAAA_AAAA and LO=0x5555_5555.
  - Start MULTU 3×5 and assert `cancel` at E10.
  - Required: `busy`=0 after the next edge, no `done`, HI/LO unchanged.
  - A following MULTU 3×5 gives LO=15, HI=0.
- **Ignored requests while busy.**
  - During a DIVU, present MTHI 0xDEADBEEF and a MULT.
  - Both are ignored and the DIVU result is exact.
  - Re-present MTHI in the cycle `done`=1: it is accepted.
- **Reset mid-op.** Assert `rst` during CALC of a DIV.
  - Required: HI=LO=0, `busy`=0, no `done` pulse.
  - The next op completes with normal latency.

Source files
------------

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register unit with iterative radix-2 multiply/divide engine
module hilo_unit #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [2:0]    op,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    input  logic          cancel,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0]   b_q, b_d, cnt_q, cnt_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic            is_div_q, is_div_d;
    logic            neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic            is_signed, sgn_a, sgn_b;
    logic [DW-1:0]   mag_a, mag_b;
    logic [DW:0]     add_sum, rem_sh, diff;
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quot_fix, rem_fix;

    always_comb begin
        // MULT and DIV are the even codes among the arithmetic ops
        is_signed = ~op[0];
        sgn_a     = is_signed & src_a[DW-1];
        sgn_b     = is_signed & src_b[DW-1];
        mag_a     = sgn_a ? -src_a : src_a;
        mag_b     = sgn_b ? -src_b : src_b;

        add_sum   = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, b_q};
        rem_sh    = acc_q[2*DW-1:DW-1];
        diff      = rem_sh - {1'b0, b_q};

        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quot_fix  = neg_res_q ? -acc_q[DW-1:0] : acc_q[DW-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];

        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_valid && !cancel) begin
                    if (!op[2]) begin
                        is_div_d  = op[1];
                        b_d       = mag_b;
                        cnt_d     = DW'(DW);
                        acc_d     = {{DW{1'b0}}, mag_a};
                        neg_res_d = sgn_a ^ sgn_b;
                        neg_rem_d = sgn_a;
                        busy_d    = 1'b1;
                        state_d   = CALC;
                        // Divide by zero: preload the final answer, FIX passes it through untouched
                        if (op[1] && src_b == '0) begin
                            acc_d     = {src_a, {DW{1'b1}}};
                            neg_res_d = 1'b0;
                            neg_rem_d = 1'b0;
                            state_d   = FIX;
                        end
                    end else if (op[1:0] == 2'b00) begin
                        hi_d = src_a;
                    end else if (op[1:0] == 2'b01) begin
                        lo_d = src_a;
                    end
                end
            end
            CALC: begin
                if (cancel) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!diff[DW]) acc_d = {diff[DW-1:0], acc_q[DW-2:0], 1'b1};
                        else           acc_d = {rem_sh[DW-1:0], acc_q[DW-2:0], 1'b0};
                    end else begin
                        if (acc_q[0]) acc_d = {add_sum, acc_q[DW-1:1]};
                        else          acc_d = {1'b0, acc_q[2*DW-1:1]};
                    end
                    cnt_d = cnt_q - DW'(1);
                    if (cnt_q == DW'(1)) state_d = FIX;
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*DW-1:DW];
                        lo_d = prod_fix[DW-1:0];
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - randomized and directed self-checking bench for hilo_unit
module tb_hilo_unit;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, op_valid, cancel;
    logic [2:0]    op;
    logic [DW-1:0] src_a, src_b;
    logic          busy, done;
    logic [DW-1:0] hi_o, lo_o;

    hilo_unit #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Reference: results from plain 64-bit arithmetic, timing as a countdown of edges
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;
    bit          m_done = 0;

    function automatic void model_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                         output logic [31:0] h, output logic [31:0] l);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     r;
        h = '0;
        l = '0;
        case (o)
            3'd0: begin r = 64'(sa * sb); h = r[63:32]; l = r[31:0]; end
            3'd1: begin r = ua * ub;      h = r[63:32]; l = r[31:0]; end
            3'd2: if (b == 0) begin h = a; l = '1; end
                  else begin r = 64'(sa / sb); l = r[31:0]; r = 64'(sa % sb); h = r[31:0]; end
            3'd3: if (b == 0) begin h = a; l = '1; end
                  else begin r = ua / ub; l = r[31:0]; r = ua % ub; h = r[31:0]; end
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                if (cancel) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; end
                end
            end else if (op_valid && !cancel) begin
                case (op)
                    3'd4: m_hi = src_a;
                    3'd5: m_lo = src_a;
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        model_result(op, src_a, src_b, p_hi, p_lo);
                        m_left = (op[1] && src_b == 0) ? 1 : DW + 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 64'(busy), 64'(m_left > 0));
            chk("cyc_done", 64'(done), 64'(m_done));
            chk("cyc_hi", 64'(hi_o), 64'(m_hi));
            chk("cyc_lo", 64'(lo_o), 64'(m_lo));
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src_a = a; src_b = b; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (busy) bcnt++;
        end
        chk("done_seen", 64'(done), 64'(1));
    endtask

    task automatic watch_no_done(input int n);
        bit seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("no_done", 64'(seen), 64'(0));
    endtask

    int lat, bcnt;

    initial begin
        rst = 1'b1; op_valid = 1'b0; cancel = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        chk("rst_hi", 64'(hi_o), 64'(0));
        chk("rst_lo", 64'(lo_o), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));

        issue(3'd4, 32'h12345678, 32'h0);
        chk("mthi_hi", 64'(hi_o), 64'h12345678);
        chk("mthi_lo", 64'(lo_o), 64'h0);
        chk("mthi_busy", 64'(busy), 64'(0));
        issue(3'd5, 32'h9ABCDEF0, 32'h0);
        chk("mtlo_lo", 64'(lo_o), 64'h9ABCDEF0);
        chk("mtlo_hi", 64'(hi_o), 64'h12345678);

        issue(3'd0, 32'hFFFFFFFF, 32'h2);
        wait_done(lat, bcnt);
        chk("mult_lat", 64'(lat), 64'(33));
        chk("mult_busy_cyc", 64'(bcnt), 64'(33));
        chk("mult_hi", 64'(hi_o), 64'hFFFFFFFF);
        chk("mult_lo", 64'(lo_o), 64'hFFFFFFFE);
        issue(3'd1, 32'hFFFFFFFF, 32'h2);
        wait_done(lat, bcnt);
        chk("multu_lat", 64'(lat), 64'(33));
        chk("multu_busy_cyc", 64'(bcnt), 64'(33));
        chk("multu_hi", 64'(hi_o), 64'h1);
        chk("multu_lo", 64'(lo_o), 64'hFFFFFFFE);

        issue(3'd2, 32'hFFFFFFF9, 32'h2);
        wait_done(lat, bcnt);
        chk("div_lo", 64'(lo_o), 64'hFFFFFFFD);
        chk("div_hi", 64'(hi_o), 64'hFFFFFFFF);
        issue(3'd3, 32'h7, 32'h0);
        wait_done(lat, bcnt);
        chk("div0_lat", 64'(lat), 64'(1));
        chk("div0_busy_cyc", 64'(bcnt), 64'(1));
        chk("div0_hi", 64'(hi_o), 64'h7);
        chk("div0_lo", 64'(lo_o), 64'hFFFFFFFF);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bcnt);
        chk("ovf_lo", 64'(lo_o), 64'h80000000);
        chk("ovf_hi", 64'(hi_o), 64'h0);

        issue(3'd4, 32'hAAAAAAAA, 32'h0);
        issue(3'd5, 32'h55555555, 32'h0);
        issue(3'd1, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'(0));
        chk("cancel_hi", 64'(hi_o), 64'hAAAAAAAA);
        chk("cancel_lo", 64'(lo_o), 64'h55555555);
        watch_no_done(40);
        issue(3'd1, 32'd3, 32'd5);
        wait_done(lat, bcnt);
        chk("after_cancel_lo", 64'(lo_o), 64'd15);
        chk("after_cancel_hi", 64'(hi_o), 64'd0);

        issue(3'd3, 32'd100, 32'd7);
        op = 3'd4; src_a = 32'hDEADBEEF; op_valid = 1'b1;
        repeat (5) @(negedge clk);
        op = 3'd0; src_a = 32'd5; src_b = 32'd6;
        repeat (5) @(negedge clk);
        op_valid = 1'b0;
        wait_done(lat, bcnt);
        chk("ign_hi", 64'(hi_o), 64'd2);
        chk("ign_lo", 64'(lo_o), 64'd14);
        issue(3'd4, 32'hDEADBEEF, 32'h0);
        chk("mthi_on_done", 64'(hi_o), 64'hDEADBEEF);
        chk("mthi_on_done_busy", 64'(busy), 64'(0));

        issue(3'd2, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_hi", 64'(hi_o), 64'h0);
        chk("rstmid_lo", 64'(lo_o), 64'h0);
        chk("rstmid_busy", 64'(busy), 64'(0));
        watch_no_done(40);
        issue(3'd2, 32'hFFFFFC18, 32'd3);
        wait_done(lat, bcnt);
        chk("rstmid_next_lat", 64'(lat), 64'(33));
        chk("rstmid_next_lo", 64'(lo_o), 64'hFFFFFEB3);
        chk("rstmid_next_hi", 64'(hi_o), 64'hFFFFFFFF);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = '1;
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'h80000000;
                default: ;
            endcase
            issue(ro, ra, rb);
            if (!ro[2]) begin
                if ($urandom_range(0, 4) == 0) begin
                    repeat ($urandom_range(0, 34)) @(negedge clk);
                    cancel = 1'b1;
                    @(negedge clk);
                    cancel = 1'b0;
                    @(negedge clk);
                end else begin
                    wait_done(lat, bcnt);
                end
            end
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
